// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream (SYNC, N, N*4 bytes, XOR checksum),
// writes little-endian words into imem and releases the core reset after a good frame.
module imem_loader #(
  parameter int          ADDR_WIDTH = 5,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int          CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic [2:0]    state_q,     state_d;
  logic [CW-1:0] n_q,         n_d;
  logic [CW-1:0] words_q,     words_d;
  logic [7:0]    chk_q,       chk_d;
  logic [1:0]    byte_idx_q,  byte_idx_d;
  logic [31:0]   word_q,      word_d;
  logic          core_rst_q,  core_rst_d;
  logic          load_done_q, load_done_d;
  logic          load_err_q,  load_err_d;

  logic accept;
  logic is_sync;
  logic n_bad;

  assign rx_ready = (state_q != S_WRITE);
  assign accept   = rx_valid && rx_ready;
  assign is_sync  = (rx_data == SYNC_BYTE);
  assign n_bad    = (rx_data == 8'd0) || (32'(rx_data) > DEPTH);

  // NOTE: every *_d gets its default (hold) first, so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    words_d     = words_q;
    chk_d       = chk_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    core_rst_d  = core_rst_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;

    case (state_q)
      // A sync byte only restarts a frame from an idle-like state; inside a frame it is payload.
      S_IDLE, S_DONE, S_ERROR: begin
        if (accept && is_sync) begin
          state_d    = S_COUNT;
          core_rst_d = 1'b1;
          load_err_d = 1'b0;
          words_d    = '0;
          chk_d      = 8'd0;
        end
      end

      S_COUNT: begin
        if (accept) begin
          if (n_bad) begin
            state_d    = S_ERROR;
            load_err_d = 1'b1;
          end else begin
            n_d        = rx_data[CW-1:0];
            chk_d      = rx_data;
            byte_idx_d = 2'd0;
            state_d    = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          case (byte_idx_q)
            2'd0:    word_d[7:0]   = rx_data;
            2'd1:    word_d[15:8]  = rx_data;
            2'd2:    word_d[23:16] = rx_data;
            default: word_d[31:24] = rx_data;
          endcase
          chk_d      = chk_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      // The write strobe is this state itself; the count advances as it is left.
      S_WRITE: begin
        words_d    = words_q + CNT_ONE;
        byte_idx_d = 2'd0;
        if ((words_q + CNT_ONE) == n_q) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_DATA;
        end
      end

      S_CHECK: begin
        if (accept) begin
          if (rx_data == chk_q) begin
            state_d     = S_DONE;
            load_done_d = 1'b1;
            core_rst_d  = 1'b0;
          end else begin
            state_d    = S_ERROR;
            load_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      words_q     <= '0;
      chk_q       <= 8'd0;
      byte_idx_q  <= 2'd0;
      word_q      <= 32'd0;
      core_rst_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      words_q     <= words_d;
      chk_q       <= chk_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      core_rst_q  <= core_rst_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign imem_we      = (state_q == S_WRITE);
  assign imem_waddr   = words_q[ADDR_WIDTH-1:0];
  assign imem_wdata   = word_q;
  assign core_rst     = core_rst_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_q;

endmodule
